// File: rtl/spi_sequencer_if.sv
// Bus window and shifter handshake bundle for spi_sequencer.
// The slave modport is the sequencer's view; master is the host/shifter side.
interface spi_sequencer_if;
    logic       bus_addr;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_wrdata;
    logic [7:0] bus_rddata;
    logic [7:0] sh_txdata;
    logic       sh_txstart;
    logic [7:0] sh_rxdata;
    logic       sh_busy;
    logic       sh_slow;
    logic       spi_cs_n;

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wrdata,
        input  sh_rxdata, sh_busy,
        output bus_rddata, sh_txdata, sh_txstart,
        output sh_slow, spi_cs_n
    );

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wrdata,
        output sh_rxdata, sh_busy,
        input  bus_rddata, sh_txdata, sh_txstart,
        input  sh_slow, spi_cs_n
    );
endinterface

// File: rtl/spi_sequencer.sv
// DATA/CTRL register window with TX/RX FIFOs driving an SPI byte shifter.
// Define SPI_SEQ_AUTOTX_EN to enable FF auto-push on DATA reads (CTRL bit2).
module spi_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    spi_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [AW:0]   r_tx_cnt, r_rx_cnt;
    logic          r_sel, r_slow, r_txovf, r_rxovf;
    logic          w_auto, w_auto_push;

    logic w_data_wr, w_ctrl_wr, w_tx_full, w_tx_empty;
    logic w_rx_full, w_rx_empty, w_tx_pop, w_rx_pop;
    logic w_tx_req, w_tx_push, w_tx_drop;
    logic w_rx_req, w_rx_push, w_rx_drop, w_busy;
    logic [7:0] w_tx_din, w_status;

    assign w_data_wr  = bus.bus_wr & ~bus.bus_addr;
    assign w_ctrl_wr  = bus.bus_wr & bus.bus_addr;
    assign w_tx_full  = (r_tx_cnt == DEPTH_C);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == DEPTH_C);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_tx_pop   = (r_state == S_START);
    assign w_rx_pop   = bus.bus_rd & ~bus.bus_addr & ~w_rx_empty;

`ifdef SPI_SEQ_AUTOTX_EN
    logic r_auto;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_auto <= 1'b0;
        else if (w_ctrl_wr) r_auto <= bus.bus_wrdata[2];
    end
    assign w_auto      = r_auto;
    assign w_auto_push = r_auto & w_rx_pop;
`else
    assign w_auto      = 1'b0;
    assign w_auto_push = 1'b0;
`endif

    // A full FIFO still accepts a push when it is popped in the same cycle
    assign w_tx_req  = w_data_wr | w_auto_push;
    assign w_tx_din  = w_data_wr ? bus.bus_wrdata : 8'hFF;
    assign w_tx_push = w_tx_req & (~w_tx_full | w_tx_pop);
    assign w_tx_drop = w_tx_req & w_tx_full & ~w_tx_pop;
    assign w_rx_req  = (r_state == S_WAIT) & ~bus.sh_busy;
    assign w_rx_push = w_rx_req & (~w_rx_full | w_rx_pop);
    assign w_rx_drop = w_rx_req & w_rx_full & ~w_rx_pop;

    assign w_busy   = (r_state != S_IDLE) | ~w_tx_empty;
    assign w_status = {w_busy, w_tx_full, w_rx_empty, r_txovf,
                       r_rxovf, w_auto, r_slow, r_sel};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_tx_empty && !bus.sh_busy) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (!bus.sh_busy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_slow  <= 1'b0;
            r_txovf <= 1'b0;
            r_rxovf <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_sel  <= bus.bus_wrdata[0];
                r_slow <= bus.bus_wrdata[1];
            end
            r_txovf <= w_tx_drop |
                       (r_txovf & ~(w_ctrl_wr & bus.bus_wrdata[4]));
            r_rxovf <= w_rx_drop |
                       (r_rxovf & ~(w_ctrl_wr & bus.bus_wrdata[3]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            r_tx_cnt <= r_tx_cnt + (AW+1)'(w_tx_push)
                                 - (AW+1)'(w_tx_pop);
            r_rx_cnt <= r_rx_cnt + (AW+1)'(w_rx_push)
                                 - (AW+1)'(w_rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= w_tx_din;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.sh_rxdata;
    end

    assign bus.sh_txstart = (r_state == S_START);
    assign bus.sh_txdata  = (r_state == S_START) ? r_tx_mem[r_tx_rp] : 8'h00;
    assign bus.sh_slow    = r_slow;
    assign bus.spi_cs_n   = ~r_sel;
    assign bus.bus_rddata = bus.bus_addr ? w_status :
                            (w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]);
endmodule
